tft_fb_reader: RTL and testbench

Parametrised framebuffer scan-out stage for the TFT/VGA path. It converts the timing generator's hcount/vcount into registered framebuffer word addresses, absorbing a fixed memory read latency. It unpacks 1–16 bpp pixels from wider memory words and expands them to RGB565 on vga_data with an aligned data-enable. It uses incremental counters, not a multiplier, and sits between the timing generator and the panel driver.

---
 rtl/tft_fb_reader.sv | 159 +++++++++++++++
 tb/tb_tft_fb_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_fb_reader.sv
// tft_fb_reader
//   Framebuffer scan-out stage between the TFT/VGA timing generator and the
//   panel driver. Tracks the framebuffer word/lane of the current pixel with
//   incremental counters, issues a registered word address, waits out the
//   memory read latency, unpacks the pixel from the returned word and expands
//   it to RGB565 together with an aligned data-enable.
//
// Parameters
//   H_ACTIVE, V_ACTIVE : active pixels per line / active lines per frame
//   BPP                : bits per pixel (1, 2, 4, 8, 16)
//   MEM_DW             : framebuffer word width, a multiple of BPP
//   AW                 : framebuffer address width
//   RD_LAT             : memory read latency in clocks (>= 1)
//
// Ports
//   clk                : pixel clock
//   rst                : asynchronous reset, active-high
//   hcount, vcount     : position from the timing generator
//   q                  : framebuffer read data
//   fg_color, bg_color : RGB565 colours for pixel values 1 / 0 (BPP=1 only)
//   address            : framebuffer word address (registered)
//   vga_data           : RGB565 pixel (registered)
//   de                 : vga_data valid (registered)
module tft_fb_reader #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int BPP      = 1,
    parameter int MEM_DW   = 1,
    parameter int AW       = 19,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic [MEM_DW-1:0] q,
    input  logic [15:0]       fg_color,
    input  logic [15:0]       bg_color,
    output logic [AW-1:0]     address,
    output logic [15:0]       vga_data,
    output logic              de
);

    localparam int PPW = MEM_DW / BPP;
    localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int OW  = (MEM_DW > 1) ? $clog2(MEM_DW) : 1;

    localparam logic [LW-1:0] LANE_LAST = LW'(PPW - 1);
    localparam logic [10:0]   H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0]   V_LIM     = 11'(V_ACTIVE);
    localparam logic [10:0]   H_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [10:0]   V_LAST    = 11'(V_ACTIVE - 1);

    // scan-in side
    logic          frame_start;
    logic          act;
    logic          scan;
    logic          synced_q, synced_d;
    logic [AW-1:0] word_q, word_d, cur_word;
    logic [LW-1:0] lane_q, lane_d, cur_lane;
    logic [AW-1:0] addr_q, addr_d;

    // latency-matching pipeline, stage 0 is loaded together with the address
    logic [RD_LAT:0]         act_pipe_q;
    logic [RD_LAT:0][LW-1:0] lane_pipe_q;

    // scan-out side
    logic [OW-1:0]  lane_off;
    logic [BPP-1:0] pix;
    logic [15:0]    colour;
    logic [15:0]    vga_q, vga_d;
    logic           de_q, de_d;

    // Counters hold the word/lane of the pixel presented this cycle. A frame
    // start overrides them combinationally so (0,0) always maps to word 0
    // lane 0, even after a mid-frame reset or corrupt timing. After reset
    // nothing is scanned until the first frame start has been seen.
    always_comb begin
        frame_start = (hcount == '0) && (vcount == '0);
        act         = (hcount < H_LIM) && (vcount < V_LIM);
        synced_d    = synced_q | frame_start;
        scan        = act && synced_d;
        cur_word    = frame_start ? '0 : word_q;
        cur_lane    = frame_start ? '0 : lane_q;

        word_d = cur_word;
        lane_d = cur_lane;
        addr_d = addr_q;

        if (scan) begin
            addr_d = cur_word;
            if ((hcount == H_LAST) && (vcount == V_LAST)) begin
                word_d = '0;
                lane_d = '0;
            end else if (cur_lane == LANE_LAST) begin
                word_d = cur_word + AW'(1);
                lane_d = '0;
            end else begin
                lane_d = cur_lane + LW'(1);
            end
        end
    end

    always_comb begin
        lane_off = OW'(32'(lane_pipe_q[RD_LAT]) * BPP);
        pix      = q[lane_off +: BPP];
    end

    generate
        if (BPP == 1) begin : g_mono
            always_comb colour = pix[0] ? fg_color : bg_color;
        end else if (BPP == 16) begin : g_direct
            always_comb colour = pix;
        end else begin : g_grey
            // Replicate the pixel MSB-first across 16 bits; each colour field
            // is then the top of that pattern.
            logic [15:0] rep;
            always_comb begin
                rep = '0;
                for (int unsigned i = 0; i < 16; i++) begin
                    rep[15-i] = pix[BPP-1-(i%BPP)];
                end
                colour = {rep[15:11], rep[15:10], rep[15:11]};
            end
        end
    endgenerate

    always_comb begin
        de_d  = act_pipe_q[RD_LAT];
        vga_d = de_d ? colour : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            synced_q    <= 1'b0;
            word_q      <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            act_pipe_q  <= '0;
            lane_pipe_q <= '0;
            vga_q       <= '0;
            de_q        <= 1'b0;
        end else begin
            synced_q    <= synced_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            act_pipe_q  <= {act_pipe_q[RD_LAT-1:0], scan};
            lane_pipe_q <= {lane_pipe_q[RD_LAT-1:0], cur_lane};
            vga_q       <= vga_d;
            de_q        <= de_d;
        end
    end

    assign address  = addr_q;
    assign vga_data = vga_q;
    assign de       = de_q;

endmodule

// File: tb/tb_tft_fb_reader.sv
// tb_tft_fb_reader
//   Three configurations of tft_fb_reader driven from one clock:
//     id 0 : 800x480, BPP=1,  MEM_DW=1,  RD_LAT=1
//     id 1 : 8x2,     BPP=4,  MEM_DW=16, RD_LAT=1
//     id 2 : 4x2,     BPP=16, MEM_DW=32, RD_LAT=3
//   Stimulus pushes expected address/pixel entries (tagged with the cycle they
//   are due) into per-instance queues; a monitor pops and compares them.
module tb_tft_fb_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [10:0] hc [3];
    logic [10:0] vc [3];
    logic [0:0]  qa;
    logic [15:0] qb;
    logic [31:0] qc;
    logic [18:0] addr_a;
    logic [3:0]  addr_b, addr_c;
    logic [3:0]  c1, c2;
    logic [15:0] vga [3];
    logic        de_o [3];

    int hact [3] = '{800, 8, 4};
    int vact [3] = '{480, 2, 2};
    int bpp  [3] = '{1, 4, 16};
    int ppw  [3] = '{1, 4, 2};
    int lat  [3] = '{1, 1, 3};

    int synced [3];
    int last_a [3];
    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int    due;
        int    val;
        string name;
    } exp_t;

    exp_t aq [3][$];
    exp_t dq [3][$];

    tft_fb_reader #(.H_ACTIVE(800), .V_ACTIVE(480), .BPP(1), .MEM_DW(1), .AW(19), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .hcount(hc[0]), .vcount(vc[0]), .q(qa),
        .fg_color(16'hFFFF), .bg_color(16'h0000),
        .address(addr_a), .vga_data(vga[0]), .de(de_o[0])
    );

    tft_fb_reader #(.H_ACTIVE(8), .V_ACTIVE(2), .BPP(4), .MEM_DW(16), .AW(4), .RD_LAT(1)) u_b (
        .clk(clk), .rst(rst), .hcount(hc[1]), .vcount(vc[1]), .q(qb),
        .fg_color(16'hFFFF), .bg_color(16'h0000),
        .address(addr_b), .vga_data(vga[1]), .de(de_o[1])
    );

    tft_fb_reader #(.H_ACTIVE(4), .V_ACTIVE(2), .BPP(16), .MEM_DW(32), .AW(4), .RD_LAT(3)) u_c (
        .clk(clk), .rst(rst), .hcount(hc[2]), .vcount(vc[2]), .q(qc),
        .fg_color(16'hFFFF), .bg_color(16'h0000),
        .address(addr_c), .vga_data(vga[2]), .de(de_o[2])
    );

    function automatic logic [31:0] memword(input int id, input int w);
        logic [31:0] r;
        r = '0;
        case (id)
            0: r = {31'b0, w[0] ^ w[3]};
            1: case (w)
                   0: r = 32'h0000_F7A0;
                   1: r = 32'h0000_3C96;
                   2: r = 32'h0000_0F1E;
                   3: r = 32'h0000_5A5A;
                   default: r = '0;
               endcase
            default: case (w)
                   0: r = 32'h1234_ABCD;
                   1: r = 32'h8421_07E0;
                   2: r = 32'hFFFF_0001;
                   3: r = 32'h0000_F81F;
                   default: r = '0;
               endcase
        endcase
        return r;
    endfunction

    // Memories with the read latency of each configuration.
    always @(posedge clk) begin
        qa <= 1'(memword(0, 32'(addr_a)));
        qb <= 16'(memword(1, 32'(addr_b)));
        c1 <= addr_c;
        c2 <= c1;
        qc <= memword(2, 32'(c2));
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int colour(input int id, input int w, input int lane);
        int p;
        logic [15:0] rep;
        p = int'(memword(id, w) >> (lane * bpp[id])) & ((1 << bpp[id]) - 1);
        if (id == 0) return (p != 0) ? 32'hFFFF : 32'h0000;
        if (id == 2) return p;
        rep = 16'(p * 32'h1111);
        return int'({rep[15:11], rep[15:10], rep[15:11]});
    endfunction

    function automatic logic [31:0] addr_of(input int id);
        case (id)
            0: return 32'(addr_a);
            1: return 32'(addr_b);
            default: return 32'(addr_c);
        endcase
    endfunction

    function automatic logic [31:0] pix_of(input int id);
        return {15'b0, de_o[id], vga[id]};
    endfunction

    task automatic check(input int id, input string nm, input logic [31:0] got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s id=%0d cyc=%0d got=%0h want=%0h", nm, id, cyc, got, want);
        end
    endtask

    // Present (h,v) for the next clock edge and queue what must come out.
    task automatic drive(input int id, input int h, input int v,
                         input int hand_a = -1, input int hand_d = -1);
        int   t, n, lane, d;
        bit   act;
        exp_t e;
        @(posedge clk);
        #1;
        hc[id] = 11'(h);
        vc[id] = 11'(v);
        t = cyc + 1;
        if (h == 0 && v == 0) synced[id] = 1;
        act = (synced[id] != 0) && (h < hact[id]) && (v < vact[id]);
        d = 0;
        if (act) begin
            n          = v * hact[id] + h;
            last_a[id] = n / ppw[id];
            lane       = n % ppw[id];
            d          = 32'h10000 | colour(id, last_a[id], lane);
        end
        e.due = t;              e.val = last_a[id]; e.name = "addr"; aq[id].push_back(e);
        e.due = t + lat[id] + 1; e.val = d;          e.name = "pix";  dq[id].push_back(e);
        if (hand_a >= 0) begin
            e.due = t; e.val = hand_a; e.name = "addr_hand"; aq[id].push_back(e);
        end
        if (hand_d >= 0) begin
            e.due = t + lat[id] + 1; e.val = hand_d; e.name = "pix_hand"; dq[id].push_back(e);
        end
    endtask

    task automatic flush_model();
        for (int id = 0; id < 3; id++) begin
            aq[id].delete();
            dq[id].delete();
            synced[id] = 0;
            last_a[id] = 0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int id = 0; id < 3; id++) begin
                while (aq[id].size() > 0 && aq[id][0].due <= cyc) begin
                    e = aq[id].pop_front();
                    check(id, e.name, addr_of(id), e.val);
                end
                while (dq[id].size() > 0 && dq[id][0].due <= cyc) begin
                    e = dq[id].pop_front();
                    check(id, e.name, pix_of(id), e.val);
                end
            end
        end
    end

    int b_a0 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int b_a1 [8] = '{2, 2, 2, 2, 3, 3, 3, 3};
    int b_d0 [4] = '{32'h10000, 32'h1AD55, 32'h173AE, 32'h1FFFF};
    int c_a  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    initial begin : stim
        rst = 1'b1;
        for (int id = 0; id < 3; id++) begin
            hc[id] = 11'h7FF;
            vc[id] = 11'h7FF;
        end
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            check(id, "reset_addr", addr_of(id), 0);
            check(id, "reset_pix", pix_of(id), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // id 0: first lines of a default frame, blanking 800..809 each line
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < ((v == 2) ? 21 : 810); h++) begin
                if (v == 2 && h == 5) drive(0, h, v, 1605, 32'h1FFFF);
                else                  drive(0, h, v);
            end
        end
        repeat (4) drive(0, 2047, 2047);

        // id 1: two full frames including line blanking and the frame wrap
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < 2; v++) begin
                for (int h = 0; h < 12; h++) begin
                    drive(1, h, v,
                          (h < 8) ? ((v == 0) ? b_a0[h] : b_a1[h]) : -1,
                          (f == 0 && v == 0 && h < 4) ? b_d0[h] : -1);
                end
            end
        end

        // id 1: reset in the middle of line 0 while de is high
        for (int h = 0; h < 4; h++) drive(1, h, 0, 0);
        @(posedge clk);
        #2;
        check(1, "de_before_reset", 32'(de_o[1]), 1);
        #1 rst = 1'b1;
        #1;
        check(1, "async_reset_addr", addr_of(1), 0);
        check(1, "async_reset_pix", pix_of(1), 0);
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        for (int h = 4; h < 12; h++) drive(1, h, 0, 0, 0);
        for (int h = 0; h < 12; h++) drive(1, h, 1, 0, 0);
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 12; h++) begin
                drive(1, h, v, (h < 8) ? ((v == 0) ? b_a0[h] : b_a1[h]) : -1,
                      (v == 0 && h < 4) ? b_d0[h] : -1);
            end
        end
        repeat (4) drive(1, 2047, 2047);

        // id 2: 16 bpp from 32-bit words, read latency 3
        repeat (3) drive(2, 2047, 2047);
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 6; h++) begin
                drive(2, h, v, (h < 4) ? c_a[v*4+h] : -1,
                      (v == 0 && h == 0) ? 32'h1ABCD :
                      (v == 0 && h == 1) ? 32'h11234 : -1);
            end
        end
        repeat (6) drive(2, 2047, 2047);

        repeat (8) @(posedge clk);
        #2;
        for (int id = 0; id < 3; id++) begin
            check(id, "leftover_expectations", 32'(aq[id].size() + dq[id].size()), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
